// File: rtl/vga_rx_monitor.sv
// Receive-side monitor for the TinyVGA PMOD byte: locks to the sync timing, recovers pixel coordinates and flags faults.
// Latency: vga_in -> pixel outputs 2 cycles; frame status updates 2 cycles after the hsync-fall byte. No backpressure: samples every cycle.
// Optional per-frame CRC-16-CCITT of the visible pixels when VGA_RX_CRC_EN is defined; otherwise frame_crc is tied to 0.
module vga_rx_monitor #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  pix_rgb,
  output logic        locked,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic        timing_err,
  output logic [15:0] frame_crc
);

  localparam logic [10:0] H_TOTAL = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [10:0] V_TOTAL = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [10:0] H_START = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_END   = 11'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [10:0] V_START = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_END   = 11'(V_SYNC + V_BACK + V_VISIBLE);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        fault_q, fault_d, err_set;
  logic [7:0]  in_q;
  logic        hs_prev, vs_prev;
  logic        hs_fall, vs_fall, boundary;
  logic [9:0]  h_cnt, v_cnt;
  logic        vs_seen;
  logic [10:0] h_len, v_len, h_pos, v_pos;
  logic        line_bad, frame_bad, h_to, v_to, h_vis, v_vis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q    <= 8'd0;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      in_q    <= vga_in;
      hs_prev <= in_q[7];
      vs_prev <= in_q[3];
    end
  end

  assign hs_fall  = hs_prev & ~in_q[7];
  assign vs_fall  = vs_prev & ~in_q[3];
  // A vsync fall coincident with an hsync fall still makes that hsync the frame boundary.
  assign boundary = hs_fall & (vs_seen | vs_fall);

  assign h_len     = {1'b0, h_cnt} + 11'd1;
  assign v_len     = {1'b0, v_cnt} + 11'd1;
  assign line_bad  = hs_fall && (h_len != H_TOTAL);
  assign frame_bad = boundary && (v_len != V_TOTAL);
  assign h_to      = &h_cnt;
  assign v_to      = &v_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt   <= 10'd0;
      v_cnt   <= 10'd0;
      vs_seen <= 1'b0;
    end else begin
      if (hs_fall)
        h_cnt <= 10'd0;
      else if (!h_to)
        h_cnt <= h_cnt + 10'd1;

      if (boundary)
        v_cnt <= 10'd0;
      else if (hs_fall && !v_to)
        v_cnt <= v_cnt + 10'd1;

      if (hs_fall)
        vs_seen <= 1'b0;
      else if (vs_fall)
        vs_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    err_set = 1'b0;
    case (state_q)
      SEARCH: begin
        if (boundary) begin
          state_d = ACQUIRE;
          fault_d = 1'b0;
        end
      end
      ACQUIRE: begin
        if (h_to || v_to) begin
          err_set = 1'b1;
          state_d = SEARCH;
        end else begin
          err_set = line_bad | frame_bad;
          if (boundary) begin
            // One fully clean frame is needed; any fault restarts the attempt.
            state_d = (fault_q | line_bad | frame_bad) ? ACQUIRE : LOCKED;
            fault_d = 1'b0;
          end else if (line_bad) begin
            fault_d = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (line_bad || frame_bad || h_to || v_to) begin
          err_set = 1'b1;
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // h_cnt lags in_q by a cycle, and v_cnt advances at hsync (mid-line), so the
  // byte now in in_q sits one position past both counters.
  assign h_pos = hs_fall ? 11'd0 : h_len;
  assign v_pos = v_len;
  assign h_vis = (h_pos >= H_START) && (h_pos < H_END);
  assign v_vis = (v_pos >= V_START) && (v_pos < V_END);
  assign locked = (state_q == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid  <= 1'b0;
      pix_x      <= 10'd0;
      pix_y      <= 10'd0;
      pix_rgb    <= 6'd0;
      frame_done <= 1'b0;
      frame_cnt  <= 8'd0;
      timing_err <= 1'b0;
    end else begin
      pix_valid  <= locked && h_vis && v_vis;
      pix_x      <= h_pos[9:0] - H_START[9:0];
      pix_y      <= v_pos[9:0] - V_START[9:0];
      pix_rgb    <= {in_q[0], in_q[4], in_q[1], in_q[5], in_q[2], in_q[6]};
      frame_done <= boundary;
      frame_cnt  <= frame_cnt + {7'd0, boundary};
      timing_err <= timing_err | err_set;
    end
  end

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc_q;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [5:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 5; i >= 0; i--)
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q     <= 16'hFFFF;
      frame_crc <= 16'h0000;
    end else if (boundary) begin
      frame_crc <= crc_q;
      crc_q     <= 16'hFFFF;
    end else if (pix_valid) begin
      crc_q <= crc_step(crc_q, pix_rgb);
    end
  end
`else
  assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor on a scaled-down raster (17x8 total, 8x4 visible) driven by a generator model.
module tb_vga_rx_monitor;

  localparam int HV = 8, HF = 4, HS = 3, HB = 2;
  localparam int VV = 4, VF = 1, VS = 1, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  vga_in = 8'h88;
  logic        pix_valid, locked, frame_done, timing_err;
  logic [9:0]  pix_x, pix_y;
  logic [5:0]  pix_rgb;
  logic [7:0]  frame_cnt;
  logic [15:0] frame_crc;

  always #5 clk = ~clk;

  vga_rx_monitor #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vga_in(vga_in),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .locked(locked), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .timing_err(timing_err), .frame_crc(frame_crc)
  );

  int tests_run = 0, tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Generator model: mode 0 solid 6'h27, 1 single white pixel at (5,2), 2 checkerboard.
  int hpos = 0, vpos = 0, mode = 0, gen_cyc = 0, fault_cyc = 0;
  bit drop_vs = 0, fault_arm = 0;

  function automatic logic [5:0] color(input int x, input int y);
    case (mode)
      0:       return 6'h27;
      1:       return (x == 5 && y == 2) ? 6'h3F : 6'h00;
      default: return (((x ^ y) & 1) != 0) ? 6'h3F : 6'h00;
    endcase
  endfunction

  initial begin
    logic hs, vs;
    logic [5:0] c;
    forever begin
      @(posedge clk);
      #1;
      if (fault_arm && vpos == 1 && hpos == HV) begin
        hpos = HV + 4;
        fault_arm = 0;
        fault_cyc = gen_cyc;
      end
      hs = !(hpos >= HV + HF && hpos < HV + HF + HS);
      vs = drop_vs ? 1'b1 : !(vpos >= VV + VF && vpos < VV + VF + VS);
      c  = (hpos < HV && vpos < VV) ? color(hpos, vpos) : 6'h00;
      vga_in = {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
      gen_cyc++;
      hpos++;
      if (hpos == HT) begin
        hpos = 0;
        vpos = (vpos + 1) % VT;
      end
    end
  end

  int pv_cnt, xmin, xmax, ymin, ymax, bad_rgb, white_cnt, white_x, white_y, fd_cnt = 0;

  task automatic clear_stats();
    pv_cnt = 0; xmin = 9999; xmax = -1; ymin = 9999; ymax = -1;
    bad_rgb = 0; white_cnt = 0; white_x = -1; white_y = -1;
  endtask

  task automatic tick();
    @(negedge clk);
    if (frame_done) fd_cnt++;
    if (pix_valid) begin
      pv_cnt++;
      if (int'(pix_x) < xmin) xmin = int'(pix_x);
      if (int'(pix_x) > xmax) xmax = int'(pix_x);
      if (int'(pix_y) < ymin) ymin = int'(pix_y);
      if (int'(pix_y) > ymax) ymax = int'(pix_y);
      if (pix_rgb != 6'h27) bad_rgb++;
      if (pix_rgb == 6'h3F) begin
        white_cnt++;
        white_x = int'(pix_x);
        white_y = int'(pix_y);
      end
    end
  endtask

  task automatic wait_bound(input int n);
    int left, budget;
    left = n;
    budget = 3 * HT * VT * n + 100;
    while (left > 0 && budget > 0) begin
      tick();
      if (frame_done) left--;
      budget--;
    end
    check("boundary_wait", 32'(left), 32'd0);
  endtask

  function automatic logic [15:0] crc_model();
    logic [15:0] r;
    logic [5:0] d;
    r = 16'hFFFF;
    for (int y = 0; y < VV; y++)
      for (int x = 0; x < HV; x++) begin
        d = (((x ^ y) & 1) != 0) ? 6'h3F : 6'h00;
        for (int i = 5; i >= 0; i--)
          r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
      end
    return r;
  endfunction

  initial begin
    int budget, fd0, fc0, lat;
    logic [15:0] crc_a, crc_b, crc_exp;
    clear_stats();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pix", 32'({pix_valid, pix_x, pix_y, pix_rgb}), 32'd0);
    check("rst_ctl", 32'({locked, frame_done, timing_err, frame_cnt}), 32'd0);
    check("rst_crc", 32'(frame_crc), 32'd0);
    rst_n = 1'b1;

    // Ideal stream, solid colour
    wait_bound(1);
    check("t1_lock_b1", 32'(locked), 32'd0);
    wait_bound(1);
    check("t1_lock_b2", 32'(locked), 32'd1);
    clear_stats();
    wait_bound(1);
    check("t1_pix_cnt", 32'(pv_cnt), 32'(HV * VV));
    check("t1_x_range", {16'(xmin), 16'(xmax)}, {16'd0, 16'(HV - 1)});
    check("t1_y_range", {16'(ymin), 16'(ymax)}, {16'd0, 16'(VV - 1)});
    check("t1_rgb", 32'(bad_rgb), 32'd0);
    check("t1_frame_cnt", 32'(frame_cnt), 32'd3);
    check("t1_err", 32'(timing_err), 32'd0);

    // Coordinate alignment: single white pixel at (5,2)
    mode = 1;
    clear_stats();
    wait_bound(1);
    check("t2_white_cnt", 32'(white_cnt), 32'd1);
    check("t2_white_xy", {16'(white_x), 16'(white_y)}, {16'd5, 16'd2});

    // Line-length fault: one line 4 clocks short
    mode = 0;
    fault_arm = 1;
    budget = 400;
    while (!timing_err && budget > 0) begin
      tick();
      budget--;
    end
    lat = gen_cyc - fault_cyc;
    check("t3_err", 32'(timing_err), 32'd1);
    check("t3_unlock", 32'(locked), 32'd0);
    check("t3_latency_le3", 32'(lat <= 3), 32'd1);
    wait_bound(1);
    check("t3_relock_b1", 32'(locked), 32'd0);
    wait_bound(1);
    check("t3_relock_b2", 32'(locked), 32'd1);
    check("t3_err_sticky", 32'(timing_err), 32'd1);

    // Missing vsync until the line counter saturates
    drop_vs = 1;
    fd0 = fd_cnt;
    fc0 = int'(frame_cnt);
    repeat (2 * HT * VT) tick();
    check("t4_still_locked", 32'(locked), 32'd1);
    budget = 20000;
    while (locked && budget > 0) begin
      tick();
      budget--;
    end
    check("t4_timeout_unlock", 32'(locked), 32'd0);
    check("t4_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
    check("t4_frame_cnt", 32'(frame_cnt), 32'(fc0));
    check("t4_err", 32'(timing_err), 32'd1);
    drop_vs = 0;
    wait_bound(1);
    check("t4_search_b1", 32'(locked), 32'd0);
    wait_bound(1);
    check("t4_relock", 32'(locked), 32'd1);

    // Mid-frame asynchronous reset
    budget = 2 * HT * VT;
    while (vpos != 2 && budget > 0) begin
      tick();
      budget--;
    end
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_pix", 32'({pix_valid, pix_x, pix_y, pix_rgb}), 32'd0);
    check("t5_rst_ctl", 32'({locked, frame_done, timing_err, frame_cnt}), 32'd0);
    check("t5_rst_crc", 32'(frame_crc), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_bound(1);
    check("t5_b1", 32'({locked, frame_cnt}), 32'({1'b0, 8'd1}));
    wait_bound(1);
    check("t5_b2", 32'({locked, timing_err, frame_cnt}), 32'({1'b1, 1'b0, 8'd2}));

    // Two identical checkerboard frames
    mode = 2;
    wait_bound(1);
    crc_a = frame_crc;
    wait_bound(1);
    crc_b = frame_crc;
`ifdef VGA_RX_CRC_EN
    crc_exp = crc_model();
`else
    crc_exp = 16'h0000;
`endif
    check("t6_crc_a", 32'(crc_a), 32'(crc_exp));
    check("t6_crc_b", 32'(crc_b), 32'(crc_exp));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
